// File: rtl/color_pkg.sv
// color_pkg: shared types and default constants for the colour-stream arbiter.
// Rev 1.0
`default_nettype none

package color_pkg;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } t_color;

  typedef enum logic {IDLE, GRANT} t_color_arb_state;

  localparam int COLOR_ARB_N     = 4;
  localparam int COLOR_ARB_BURST = 4;

endpackage

`default_nettype wire

// File: rtl/color_arb_rr.sv
// color_arb_rr: combinational round-robin picker, searches last+1, last+2, ... modulo N.
// Rev 1.0
`default_nettype none

module color_arb_rr
  import color_pkg::*;
#(
  parameter  int N  = COLOR_ARB_N,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] sel
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    any   = |req;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(last) + i) % N);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/color_arbiter.sv
// color_arbiter: round-robin burst arbiter feeding the RGB datapath through a registered stage.
// Rev 1.0 -- optional COLOR_ARB_LOCK_EN adds req_lock to extend a grant past BURST.
`default_nettype none

module color_arbiter
  import color_pkg::*;
#(
  parameter  int N     = COLOR_ARB_N,
  parameter  int BURST = COLOR_ARB_BURST,
  localparam int IW    = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
`ifdef COLOR_ARB_LOCK_EN
  input  logic [N-1:0]  req_lock,
`endif
  input  logic [N-1:0]  req_vld,
  output logic [N-1:0]  req_rdy,
  input  t_color        req_color [N],
  output logic          out_vld,
  input  logic          out_rdy,
  output t_color        out_color,
  output logic [IW-1:0] out_id,
  output logic          busy
);

  localparam int            CW      = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST - 1);

  t_color_arb_state state, state_nxt;
  logic [IW-1:0]    gnt;
  logic [IW-1:0]    last;
  logic [CW-1:0]    cnt;

  logic          rr_any;
  logic [IW-1:0] rr_sel;
  logic          is_grant;
  logic          slot_open;
  logic          xfer;
  logic          lock_g;
  logic          burst_end;
  logic          abandon;
  logic          grant_done;

  color_arb_rr #(.N(N)) u_rr (
    .req  (req_vld),
    .last (last),
    .any  (rr_any),
    .sel  (rr_sel)
  );

`ifdef COLOR_ARB_LOCK_EN
  assign lock_g = req_lock[gnt];
`else
  assign lock_g = 1'b0;
`endif

  assign is_grant   = (state == GRANT);
  assign slot_open  = !out_vld || out_rdy;
  assign xfer       = is_grant && slot_open && req_vld[gnt];
  assign burst_end  = xfer && (cnt == CNT_MAX) && !lock_g;
  // A requester that withdraws while it could have been accepted forfeits the grant.
  assign abandon    = is_grant && slot_open && !req_vld[gnt];
  assign grant_done = burst_end || abandon;
  assign busy       = is_grant;

  always_comb begin
    req_rdy = '0;
    if (is_grant) req_rdy[gnt] = slot_open;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rr_any) state_nxt = GRANT;
      GRANT:   if (grant_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= '0;
      last      <= IW'(N - 1);
      cnt       <= '0;
      out_vld   <= 1'b0;
      out_color <= '{r: 8'h00, g: 8'h00, b: 8'h00};
      out_id    <= '0;
    end else begin
      if (!is_grant && rr_any) begin
        gnt <= rr_sel;
        cnt <= '0;
      end
      // Saturating: only a locked grant can transfer past CNT_MAX.
      if (xfer && (cnt != CNT_MAX)) cnt <= cnt + 1'b1;
      if (grant_done) last <= gnt;
      if (xfer) begin
        out_vld   <= 1'b1;
        out_color <= req_color[gnt];
        out_id    <= gnt;
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
